mux21_arbiter: RTL and testbench

MUX21_ARBITER -- requirements
Module: mux21_arbiter

---
 rtl/mux21_arbiter_pkg.sv | 16 +
 rtl/mux21_arbiter_mux21.sv | 18 +
 rtl/mux21_arbiter.sv | 102 ++++++++++
 tb/tb_mux21_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mux21_arbiter_pkg.sv
// Shared defaults and encodings for the two-source arbiter and its data mux.
package mux21_arbiter_pkg;

  localparam int unsigned WIDTH_DEF = 4;
  localparam int unsigned BURST_DEF = 2;

  // Source tag encoding, shared by the arbiter sel output and mux_21 sel.
  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_t;

endpackage

// File: rtl/mux21_arbiter_mux21.sv
// Plain 2:1 data mux; sel = SRC_B picks b, otherwise a.
module mux_21
  import mux21_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] f_c
);

  // Combinational select.
  always_comb begin
    f_c = (sel == SRC_B) ? b : a;
  end

endmodule

// File: rtl/mux21_arbiter.sv
// Two-source burst-limited arbiter feeding a registered output word with
// valid/ready drain. Grants are combinational acknowledges to the sources.
module mux21_arbiter
  import mux21_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned BURST = BURST_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic             req_a,
  input  logic [WIDTH-1:0] b,
  input  logic             req_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic [WIDTH-1:0] f,
  output logic             sel,
  output logic             f_valid,
  input  logic             f_ready
);

  localparam int unsigned CNT_W = $clog2(BURST + 1);

  owner_t           owner;
  owner_t           owner_nxt;
  logic [CNT_W-1:0] burst_cnt;
  logic [CNT_W-1:0] burst_cnt_nxt;
  logic             load_en;
  logic             pick_b;
  logic [WIDTH-1:0] mux_f;

  // Output register can take a word when empty or being drained this cycle.
  assign load_en = !f_valid || f_ready;

  // Data path: grant decision steers the mux.
  mux_21 #(
    .WIDTH (WIDTH)
  ) u_mux (
    .a   (a),
    .b   (b),
    .sel (pick_b),
    .f_c (mux_f)
  );

  // Arbiter state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner     <= OWN_A;
      burst_cnt <= '0;
    end else begin
      owner     <= owner_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

  // Grant decision and next arbiter state; owner keeps priority until it
  // has used its burst, burst count saturates and only resets on handover.
  always_comb begin
    gnt_a         = 1'b0;
    gnt_b         = 1'b0;
    pick_b        = 1'b0;
    owner_nxt     = owner;
    burst_cnt_nxt = burst_cnt;

    if (!rst && load_en) begin
      if (req_a && req_b) begin
        if (burst_cnt < CNT_W'(BURST)) pick_b = (owner == OWN_B);
        else                           pick_b = (owner == OWN_A);
      end else begin
        pick_b = req_b;
      end
      gnt_a = req_a && !pick_b;
      gnt_b = req_b && pick_b;
    end

    if (gnt_a || gnt_b) begin
      if (pick_b == (owner == OWN_B)) begin
        if (burst_cnt != CNT_W'(BURST)) burst_cnt_nxt = burst_cnt + CNT_W'(1);
      end else begin
        owner_nxt     = pick_b ? OWN_B : OWN_A;
        burst_cnt_nxt = CNT_W'(1);
      end
    end
  end

  // Output word register: load on grant, clear valid on drain without reload.
  always_ff @(posedge clk) begin
    if (rst) begin
      f       <= '0;
      sel     <= SRC_A;
      f_valid <= 1'b0;
    end else if (gnt_a || gnt_b) begin
      f       <= mux_f;
      sel     <= pick_b ? SRC_B : SRC_A;
      f_valid <= 1'b1;
    end else if (f_ready) begin
      f_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux21_arbiter.sv
// Bench for mux21_arbiter: directed scenarios with literal expectations plus a
// per-cycle comparison against a behavioural model of the arbitration rules.
module tb_mux21_arbiter;

  localparam int WIDTH = 4;
  localparam int BURST = 2;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] a;
  logic             req_a;
  logic [WIDTH-1:0] b;
  logic             req_b;
  logic             gnt_a;
  logic             gnt_b;
  logic [WIDTH-1:0] f;
  logic             sel;
  logic             f_valid;
  logic             f_ready;

  int checks = 0;
  int errors = 0;
  bit model_on = 0;

  // Model state: what the output register and arbiter must hold.
  int               m_owner = 0;
  int               m_run   = 0;
  logic [WIDTH-1:0] m_f     = '0;
  int               m_sel   = 0;
  int               m_valid = 0;

  mux21_arbiter #(
    .WIDTH (WIDTH),
    .BURST (BURST)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .req_a   (req_a),
    .b       (b),
    .req_b   (req_b),
    .gnt_a   (gnt_a),
    .gnt_b   (gnt_b),
    .f       (f),
    .sel     (sel),
    .f_valid (f_valid),
    .f_ready (f_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic ra, input logic rb, input logic rdy,
                       input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb);
    @(posedge clk);
    #1;
    rst = r; req_a = ra; req_b = rb; f_ready = rdy; a = va; b = vb;
  endtask

  // Per-cycle comparison against the model, then advance the model by one edge.
  always @(negedge clk) begin
    if (model_on) begin
      int  win;
      bit  can_load;
      bit  exp_ga;
      bit  exp_gb;
      can_load = (m_valid == 0) || (f_ready == 1'b1);
      win = -1;
      if (!rst && can_load) begin
        if (req_a && !req_b)      win = 0;
        else if (req_b && !req_a) win = 1;
        else if (req_a && req_b)  win = (m_run < BURST) ? m_owner : 1 - m_owner;
      end
      exp_ga = (win == 0);
      exp_gb = (win == 1);

      chk("m_gnt_a",   32'(gnt_a),   32'(exp_ga));
      chk("m_gnt_b",   32'(gnt_b),   32'(exp_gb));
      chk("m_f_valid", 32'(f_valid), 32'(m_valid));
      chk("m_f",       32'(f),       32'(m_f));
      chk("m_sel",     32'(sel),     32'(m_sel));
      chk("one_grant", 32'(gnt_a && gnt_b), 32'(0));
      if (f_valid && !f_ready) chk("stall_no_grant", 32'(gnt_a || gnt_b), 32'(0));

      if (rst) begin
        m_owner = 0; m_run = 0; m_f = '0; m_sel = 0; m_valid = 0;
      end else if (win >= 0) begin
        if (win == m_owner) begin
          m_run = (m_run + 1 > BURST) ? BURST : m_run + 1;
        end else begin
          m_owner = win;
          m_run   = 1;
        end
        m_f     = (win == 1) ? b : a;
        m_sel   = win;
        m_valid = 1;
      end else if (m_valid != 0 && f_ready) begin
        m_valid = 0;
      end
    end
  end

  logic [5:0] exp_g;
  logic [5:0] g_seq;
  logic [5:0] ga_seq;
  logic [5:0] s_seq;

  initial begin
    rst = 1'b1; req_a = 1'b1; req_b = 1'b1; f_ready = 1'b1;
    a = 4'b0011; b = 4'b1100;

    // Reset held two cycles with both sources requesting.
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_gnt_a",   32'(gnt_a),   32'(0));
    chk("rst_gnt_b",   32'(gnt_b),   32'(0));
    chk("rst_f_valid", 32'(f_valid), 32'(0));
    chk("rst_f",       32'(f),       32'(0));
    chk("rst_sel",     32'(sel),     32'(0));
    model_on = 1;

    // Contention from reset: A,A,B,B,A,A with sel trailing by one cycle.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4'b0011, 4'b1100);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      g_seq[i]  = gnt_b;
      ga_seq[i] = gnt_a;
      if (i > 0) s_seq[i-1] = sel;
    end
    @(negedge clk);
    s_seq[5] = sel;
    exp_g = 6'b001100;
    for (int i = 0; i < 6; i++) begin
      chk("cont_gnt_b", 32'(g_seq[i]),  32'(exp_g[i]));
      chk("cont_gnt_a", 32'(ga_seq[i]), 32'(!exp_g[i]));
      chk("cont_sel",   32'(s_seq[i]),  32'(exp_g[i]));
    end

    // Idle one cycle to drain, then a single source streams.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 4'b1010, 4'b0000);
    @(negedge clk);
    chk("single_first_valid", 32'(f_valid), 32'(0));
    chk("single_first_gnt",   32'(gnt_a),   32'(1));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("single_gnt_a",   32'(gnt_a),   32'(1));
      chk("single_f",       32'(f),       32'(4'b1010));
      chk("single_sel",     32'(sel),     32'(0));
      chk("single_f_valid", 32'(f_valid), 32'(1));
    end

    // Backpressure: 1111 held while B waits, then released.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 4'b1111, 4'b0000);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_f",       32'(f),       32'(4'b1111));
      chk("bp_f_valid", 32'(f_valid), 32'(1));
      chk("bp_gnt_b",   32'(gnt_b),   32'(0));
    end
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'b1111, 4'b0000);
    @(negedge clk);
    chk("bp_release_gnt_b", 32'(gnt_b), 32'(1));
    drive(1'b0, 1'b0, 1'b0, 1'b1, 4'b1111, 4'b0000);
    @(negedge clk);
    chk("bp_release_f",   32'(f),   32'(4'b0000));
    chk("bp_release_sel", 32'(sel), 32'(1));

    // Reset mid-operation while B owns and a word 0101 is held.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 4'b0101);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0101);
    @(negedge clk);
    chk("mid_held_f",     32'(f),       32'(4'b0101));
    chk("mid_held_valid", 32'(f_valid), 32'(1));
    drive(1'b1, 1'b1, 1'b1, 1'b0, 4'b0011, 4'b1100);
    @(negedge clk);
    chk("mid_rst_gnt", 32'({gnt_a, gnt_b}), 32'(0));
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4'b0011, 4'b1100);
    @(negedge clk);
    chk("mid_after_valid", 32'(f_valid), 32'(0));
    chk("mid_after_f",     32'(f),       32'(0));
    chk("mid_after_gnt_a", 32'(gnt_a),   32'(1));
    chk("mid_after_gnt_b", 32'(gnt_b),   32'(0));

    // Mixed traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 120; i++) begin
      drive(1'($urandom_range(0, 24) == 0), 1'($urandom), 1'($urandom),
            1'($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom));
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
